div_unit: RTL

- Multi-cycle RV32M divider executing DIV, DIVU, REM and REMU.
- It is the inverse companion to the single-cycle ALU multiply path. The execute stage hands off operands, stalls while busy, and captures the result on done.
- Radix-2 restoring algorithm on magnitudes, one quotient bit per cycle, with a final sign-fix cycle.
- RISC-V divide-by-zero and signed-overflow results are produced by a fast path with no iteration.

---
 rtl/div_unit.sv | 125 ++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU): radix-2 restoring on magnitudes,
// one quotient bit per cycle, then one sign-fix cycle; div-by-zero and overflow bypass iteration.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      div_op,
  input  logic [XLEN-1:0] div_op_x,
  input  logic [XLEN-1:0] div_op_y,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] div_result
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // div_op encoding: bit 1 selects remainder, bit 0 selects unsigned.
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state;
  logic [4:0]      count;
  logic [1:0]      op;
  logic            sign_x;
  logic            sign_y;
  logic [XLEN-1:0] mag_y;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quot;

  logic            in_signed;
  logic            in_sx;
  logic            in_sy;
  logic [XLEN-1:0] in_mag_x;
  logic [XLEN-1:0] in_mag_y;
  logic            in_div_zero;
  logic            in_overflow;
  logic [XLEN:0]   shifted;
  logic            fits;
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] quot_fixed;
  logic [XLEN-1:0] rem_fixed;

  assign busy = (state == CALC) || (state == FIX);
  assign done = (state == DONE);

  // NOTE: every variable driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    in_signed   = ~div_op[0];
    in_sx       = in_signed & div_op_x[XLEN-1];
    in_sy       = in_signed & div_op_y[XLEN-1];
    in_mag_x    = in_sx ? (~div_op_x + 1'b1) : div_op_x;
    in_mag_y    = in_sy ? (~div_op_y + 1'b1) : div_op_y;
    in_div_zero = (div_op_y == '0);
    in_overflow = in_signed && (div_op_x == MIN_NEG) && (div_op_y == '1);

    // Trial subtraction: the 33-bit partial remainder is compared against |y|; when it
    // fits, the low 32 bits of the difference are exact because the result is below |y|.
    shifted  = {rem, quot[XLEN-1]};
    fits     = (shifted >= {1'b0, mag_y});
    rem_next = fits ? (shifted[XLEN-1:0] - mag_y) : shifted[XLEN-1:0];

    quot_fixed = (~op[1] & (sign_x ^ sign_y)) ? (~quot + 1'b1) : quot;
    rem_fixed  = (op[1] & sign_x) ? (~rem + 1'b1) : rem;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every register, datapath included, is cleared so no stale operand survives a reset.
      state      <= IDLE;
      count      <= '0;
      op         <= '0;
      sign_x     <= 1'b0;
      sign_y     <= 1'b0;
      mag_y      <= '0;
      rem        <= '0;
      quot       <= '0;
      div_result <= '0;
    end else if (kill) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op     <= div_op;
            sign_x <= in_sx;
            sign_y <= in_sy;
            mag_y  <= in_mag_y;
            count  <= '0;
            rem    <= '0;
            quot   <= in_mag_x;
            if (in_div_zero) begin
              div_result <= div_op[1] ? div_op_x : '1;
              state      <= DONE;
            end else if (in_overflow) begin
              div_result <= div_op[1] ? '0 : MIN_NEG;
              state      <= DONE;
            end else begin
              state <= CALC;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          rem   <= rem_next;
          quot  <= {quot[XLEN-2:0], fits};
          count <= count + 1'b1;
          if (count == 5'd31) state <= FIX;
        end
        FIX: begin
          div_result <= op[1] ? rem_fixed : quot_fixed;
          state      <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
